cv_ce_gen: RTL and testbench
============================

Name: cv_ce_gen

Overview:
Multi-channel programmable clock-enable generator. It is the parametrised successor of the fixed single-channel clock-enable divider.
- Each channel divides CLK by a divisor written at runtime.
- Each channel has its own enable and a periodic/one-shot mode.
- A global SYNC phase-aligns all channels.
- It feeds CE strobes to the sequence-generator datapath and to peripheral timing logic.

Parameters:
CNT_WDT, 8, width of each channel counter and divisor register
CH_NUM, 4, number of channels (1..16)
ADDR_WDT, 2, width of WADDR; must satisfy 2**ADDR_WDT >= CH_NUM
DIV_DEF, 8, per-channel divisor after reset (1..2**CNT_WDT-1)

Ports:
CLK  in  1  clock, rising-edge
RST  in  1  asynchronous reset, active-high
WE  in  1  divisor write strobe
WADDR  in  ADDR_WDT  channel index for write
WDATA  in  CNT_WDT  divisor value
EN  in  CH_NUM  per-channel count enable (level)
ONESHOT  in  CH_NUM  per-channel mode: 0 periodic, 1 one-shot
SYNC  in  1  synchronous restart of all channels
CEO  out  CH_NUM  per-channel clock-enable pulse, registered
DONE  out  CH_NUM  per-channel one-shot completed flag, registered

Behaviour:
- Reset state (RST high, async), per channel:
  - DIV = DIV_DEF.
  - Counter CNT = 0.
  - CEO = 0, DONE = 0.
- Effective divisor: DIVE = (DIV < 2) ? 1 : DIV. Values 0 and 1 both mean "pulse every enabled cycle".
- Per channel, each rising edge, in priority order:
  1. SYNC=1: CNT<=0, CEO<=0, DONE<=0 for every channel.
  2. EN[i]=0: CNT holds, CEO<=0, DONE<=0. Dropping EN re-arms a completed one-shot.
  3. DONE[i]=1: CNT<=0, CEO<=0, DONE holds 1. The channel is halted.
  4. CNT >= DIVE-1: CNT<=0, CEO<=1, DONE<=ONESHOT[i].
  5. Otherwise: CNT<=CNT+1, CEO<=0.
- Periodic timing: with EN held high after reset or SYNC, CEO is high for exactly 1 cycle every DIVE cycles. The first CEO rises on the DIVE-th rising edge after enable.
- The ">=" compare handles a divisor lowered below the current CNT. The channel wraps on the next enabled edge and emits CEO there, with no counter overrun.
- Divisor write: on an edge with WE=1, DIV[WADDR] <= WDATA.
  - The compare on the same edge uses the old DIV; the new value is used from the next edge.
  - A write does not clear CNT.
  - If WADDR >= CH_NUM, the write is ignored.
- Write and SYNC on the same edge: the write is applied and the counters clear. The new divisor is used for the first period after SYNC.
- One-shot: at the emitted pulse, DONE rises together with CEO. CEO falls the next cycle and DONE stays high.
  - Re-arm paths: EN low for at least 1 cycle, or SYNC.
  - Changing ONESHOT while DONE=1 does not clear DONE.
- Channels are fully independent apart from SYNC and the shared write bus.
- No combinational paths from inputs to outputs.
- RST asserted mid-period clears everything immediately, with no glitch on the CEO register. Counting restarts on the first edge after RST is released.

Test Plan:
- Reset defaults: release RST, EN=4'b0001, no writes -> CEO[0] pulses at edges 8, 16, 24. CEO[3:1] stay 0 and DONE=0.
- Runtime divisor: write WADDR=1, WDATA=3, then set EN[1]=1 -> CEO[1] is high 1 cycle in every 3. Write WDATA=0 -> CEO[1] stays high on every enabled cycle.
- Lowering the divisor mid-count:
  - Channel 0: DIV=8, wait until CNT=5, then write DIV=2.
  - Expect CEO[0] on the next edge, then a pulse every 2 cycles.
- One-shot, channel 2: DIV=5, ONESHOT=1, EN=1.
  - Expect a single CEO[2] pulse at edge 5, with DONE[2]=1 from then on and no further pulses.
  - Drop EN[2] for 1 cycle, then raise it -> the next pulse comes 5 cycles later.
- SYNC alignment: channels 0/1 with DIV=4/6 running at unrelated phases, then SYNC for 1 cycle -> both counters restart. CEO[0] appears 4 edges and CEO[1] 6 edges after SYNC release; both coincide at edge 12.
- Async reset mid-operation: assert RST between clock edges while CNT=3 -> CEO/DONE go 0 immediately and DIV returns to DIV_DEF. After release, the first CEO arrives at edge 8. A write to WADDR=3 with CH_NUM=3 has no effect.

Source files
------------

// File: rtl/cv_ce_gen.sv
// Multi-channel programmable clock-enable generator: each channel divides CLK by a
// runtime divisor and emits a one-cycle registered CEO strobe, periodic or one-shot.
module cv_ce_gen #(
    parameter int unsigned CNT_WDT  = 8,
    parameter int unsigned CH_NUM   = 4,
    parameter int unsigned ADDR_WDT = 2,
    parameter int unsigned DIV_DEF  = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                WE,
    input  logic [ADDR_WDT-1:0] WADDR,
    input  logic [CNT_WDT-1:0]  WDATA,
    input  logic [CH_NUM-1:0]   EN,
    input  logic [CH_NUM-1:0]   ONESHOT,
    input  logic                SYNC,
    output logic [CH_NUM-1:0]   CEO,
    output logic [CH_NUM-1:0]   DONE
);

    logic [CNT_WDT-1:0] div_q [CH_NUM];
    logic [CNT_WDT-1:0] div_d [CH_NUM];
    logic [CNT_WDT-1:0] cnt_q [CH_NUM];
    logic [CNT_WDT-1:0] cnt_d [CH_NUM];
    logic [CNT_WDT-1:0] lim   [CH_NUM];
    logic [CH_NUM-1:0]  ceo_q, ceo_d;
    logic [CH_NUM-1:0]  done_q, done_d;

    // Out-of-range addresses match no channel, so such writes fall away naturally.
    always_comb begin
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            div_d[i] = div_q[i];
            if (WE && (WADDR == ADDR_WDT'(i))) begin
                div_d[i] = WDATA;
            end
        end
    end

    // Terminal count is DIVE-1; divisors 0 and 1 both collapse to a terminal count of 0.
    always_comb begin
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            lim[i] = (div_q[i] < CNT_WDT'(2)) ? '0 : div_q[i] - CNT_WDT'(1);
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            cnt_d[i]  = cnt_q[i];
            ceo_d[i]  = 1'b0;
            done_d[i] = done_q[i];
            if (SYNC) begin
                cnt_d[i]  = '0;
                done_d[i] = 1'b0;
            end else if (!EN[i]) begin
                done_d[i] = 1'b0;
            end else if (done_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= lim[i]) begin
                // >= lets a divisor lowered below the running count wrap at once.
                cnt_d[i]  = '0;
                ceo_d[i]  = 1'b1;
                done_d[i] = ONESHOT[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_WDT'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                div_q[i] <= CNT_WDT'(DIV_DEF);
                cnt_q[i] <= '0;
            end
            ceo_q  <= '0;
            done_q <= '0;
        end else begin
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                div_q[i] <= div_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            ceo_q  <= ceo_d;
            done_q <= done_d;
        end
    end

    assign CEO  = ceo_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_cv_ce_gen.sv
// Self-checking bench for cv_ce_gen: directed scenarios plus a randomized run against
// a cycle-level behavioural model of the channel rules.
module tb_cv_ce_gen;

    localparam int CW = 8;
    localparam int CN = 4;
    localparam int AW = 2;
    localparam int DD = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          WE = 1'b0;
    logic [AW-1:0] WADDR = '0;
    logic [CW-1:0] WDATA = '0;
    logic [CN-1:0] EN = '0;
    logic [CN-1:0] ONESHOT = '0;
    logic          SYNC = 1'b0;
    logic [CN-1:0] CEO, DONE;
    logic [2:0]    ceo3, done3;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: cycles elapsed in the current period, per channel.
    int        m_div [CN];
    int        m_cnt [CN];
    bit [CN-1:0] m_ceo, m_done;

    always #5 CLK = ~CLK;

    cv_ce_gen #(.CNT_WDT(CW), .CH_NUM(CN), .ADDR_WDT(AW), .DIV_DEF(DD)) dut (
        .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .WDATA(WDATA), .EN(EN),
        .ONESHOT(ONESHOT), .SYNC(SYNC), .CEO(CEO), .DONE(DONE)
    );

    // Three-channel instance: address 3 is out of range and must be ignored.
    cv_ce_gen #(.CNT_WDT(CW), .CH_NUM(3), .ADDR_WDT(AW), .DIV_DEF(DD)) dut3 (
        .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .WDATA(WDATA), .EN(EN[2:0]),
        .ONESHOT(ONESHOT[2:0]), .SYNC(SYNC), .CEO(ceo3), .DONE(done3)
    );

    task automatic model_reset();
        for (int i = 0; i < CN; i++) begin
            m_div[i] = DD;
            m_cnt[i] = 0;
        end
        m_ceo  = '0;
        m_done = '0;
    endtask

    task automatic model_edge();
        int          nd [CN];
        bit [CN-1:0] nc, ndn;
        for (int i = 0; i < CN; i++) begin
            int period;
            nd[i] = (WE && int'(WADDR) == i) ? int'(WDATA) : m_div[i];
            period = (m_div[i] < 2) ? 1 : m_div[i];
            nc[i]  = 1'b0;
            ndn[i] = m_done[i];
            if (SYNC) begin
                m_cnt[i] = 0;
                ndn[i]   = 1'b0;
            end else if (!EN[i]) begin
                ndn[i] = 1'b0;
            end else if (m_done[i]) begin
                m_cnt[i] = 0;
            end else if (m_cnt[i] + 1 >= period) begin
                m_cnt[i] = 0;
                nc[i]    = 1'b1;
                ndn[i]   = ONESHOT[i];
            end else begin
                m_cnt[i]++;
            end
        end
        for (int i = 0; i < CN; i++) m_div[i] = nd[i];
        m_ceo  = nc;
        m_done = ndn;
    endtask

    // One clock edge; outputs are sampled 1 time unit later.
    task automatic clk_step();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic write_div(input int addr, input int val);
        WE = 1'b1; WADDR = AW'(addr); WDATA = CW'(val);
        clk_step();
        WE = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({CEO, DONE} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b required 0", {CEO, DONE});
        end
        @(negedge CLK);
        RST = 1'b0;
        EN  = 4'b0001;
        model_reset();
        for (int k = 1; k <= 24; k++) begin
            clk_step();
            n_checks++;
            if ({CEO, DONE} !== {((k % 8 == 0) ? 4'b0001 : 4'b0000), 4'b0000}) begin
                n_fail++;
                $display("FAIL reset_default_div edge=%0d got %b/%b", k, CEO, DONE);
            end
        end
    endtask

    task automatic test_runtime_div();
        write_div(1, 3);
        EN[1] = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            clk_step();
            n_checks++;
            if (CEO[1] !== (k % 3 == 0)) begin
                n_fail++;
                $display("FAIL div3 edge=%0d got %b required %b", k, CEO[1], (k % 3 == 0));
            end
        end
        write_div(1, 0);
        for (int k = 1; k <= 5; k++) begin
            clk_step();
            n_checks++;
            if (CEO[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL div0 edge=%0d got %b required 1", k, CEO[1]);
            end
        end
    endtask

    task automatic test_lower_div();
        SYNC = 1'b1;
        clk_step();
        SYNC = 1'b0;
        repeat (5) clk_step();
        write_div(0, 2);
        n_checks++;
        if (CEO[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL lower_div_write_edge got %b required 0", CEO[0]);
        end
        for (int k = 1; k <= 8; k++) begin
            clk_step();
            n_checks++;
            if (CEO[0] !== (k % 2 == 1)) begin
                n_fail++;
                $display("FAIL lower_div edge=%0d got %b required %b", k, CEO[0], (k % 2 == 1));
            end
        end
    endtask

    task automatic test_oneshot();
        write_div(2, 5);
        ONESHOT[2] = 1'b1;
        EN[2] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            clk_step();
            n_checks++;
            if ({CEO[2], DONE[2]} !== {(k == 5), (k >= 5)}) begin
                n_fail++;
                $display("FAIL oneshot edge=%0d got ceo=%b done=%b", k, CEO[2], DONE[2]);
            end
        end
        EN[2] = 1'b0;
        clk_step();
        n_checks++;
        if (DONE[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_rearm got done=%b required 0", DONE[2]);
        end
        EN[2] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            clk_step();
            n_checks++;
            if ({CEO[2], DONE[2]} !== {(k == 5), (k >= 5)}) begin
                n_fail++;
                $display("FAIL oneshot_again edge=%0d got ceo=%b done=%b", k, CEO[2], DONE[2]);
            end
        end
    endtask

    task automatic test_sync();
        EN = 4'b0011;
        ONESHOT = '0;
        write_div(0, 4);
        write_div(1, 6);
        repeat ($urandom_range(3, 11)) clk_step();
        SYNC = 1'b1;
        clk_step();
        SYNC = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            clk_step();
            n_checks++;
            if (CEO[1:0] !== {(k % 6 == 0), (k % 4 == 0)}) begin
                n_fail++;
                $display("FAIL sync_align edge=%0d got %b required %b", k, CEO[1:0],
                         {(k % 6 == 0), (k % 4 == 0)});
            end
        end
    endtask

    task automatic test_async_reset();
        write_div(0, 20);
        write_div(2, 3);
        EN = 4'b0101;
        ONESHOT = 4'b0100;
        SYNC = 1'b1;
        clk_step();
        SYNC = 1'b0;
        repeat (3) clk_step();
        n_checks++;
        if ({CEO[2], DONE[2]} !== 2'b11) begin
            n_fail++;
            $display("FAIL pre_reset_oneshot got %b required 11", {CEO[2], DONE[2]});
        end
        #2;
        RST = 1'b1;
        #1;
        n_checks++;
        if ({CEO, DONE} !== '0) begin
            n_fail++;
            $display("FAIL async_reset got %b required 0", {CEO, DONE});
        end
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
        EN = 4'b1111;
        ONESHOT = '0;
        WE = 1'b1; WADDR = 2'd3; WDATA = 8'd2;
        for (int k = 1; k <= 16; k++) begin
            clk_step();
            WE = 1'b0;
            n_checks++;
            if ({ceo3, CEO[0]} !== ((k % 8 == 0) ? 4'b1111 : 4'b0000)) begin
                n_fail++;
                $display("FAIL post_reset edge=%0d got ceo3=%b ceo0=%b", k, ceo3, CEO[0]);
            end
        end
        n_checks++;
        if (m_div[3] != 2 || CEO[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL ch3_write got ceo3=%b required 1", CEO[3]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            WE    = ($urandom_range(0, 9) == 0);
            WADDR = AW'($urandom_range(0, 3));
            WDATA = CW'($urandom_range(0, 9));
            SYNC  = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < CN; i++) EN[i] = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 29) == 0) ONESHOT = CN'($urandom);
            clk_step();
            n_checks++;
            if ({CEO, DONE} !== {m_ceo, m_done}) begin
                n_fail++;
                $display("FAIL random_main cyc=%0d got %b/%b required %b/%b", n, CEO, DONE,
                         m_ceo, m_done);
            end
            n_checks++;
            if ({ceo3, done3} !== {m_ceo[2:0], m_done[2:0]}) begin
                n_fail++;
                $display("FAIL random_ch3 cyc=%0d got %b/%b required %b/%b", n, ceo3, done3,
                         m_ceo[2:0], m_done[2:0]);
            end
        end
        WE = 1'b0;
        SYNC = 1'b0;
    endtask

    initial begin
        test_reset();
        test_runtime_div();
        test_lower_div();
        test_oneshot();
        test_sync();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
